alu_wb: RTL and testbench
=========================

ALU_WB -- requirements
Module: alu_wb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; no other clock or reset input.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  ALU result present this cycle.
REQ-005 in_ready  output  1  block can accept a result this cycle.
REQ-006 in_result  input  12  ALU a_out.
REQ-007 in_carry  input  1  ALU carry_out.
REQ-008 in_equ  input  1  ALU equ_out.
REQ-009 in_ovf  input  1  ALU overflow_out.
REQ-010 in_dest  input  2  destination register index, R0..R3.
REQ-011 in_flag_we  input  1  result updates the flags register.
REQ-012 commit_en  input  1  writeback may retire one entry this cycle.
REQ-013 rd_a_idx, rd_b_idx  input  2 each  register read indices.
REQ-014 rd_a, rd_b  output  12 each  combinational reads of committed register file, feeding ALU a_in/b_in.
REQ-015 carry_fb  output  1  committed C flag, feeding ALU carry_in.
REQ-016 flags  output  3  committed {V, E, C}, bit 2 = V, bit 0 = C.
REQ-017 pending  output  2  number of buffered, uncommitted entries (0..2).
REQ-018 commit_count  output  16  number of retired entries.

Function
REQ-019 A result SHALL be accepted on a rising edge exactly when in_valid and in_ready are both high; a record holds {result, carry, equ, ovf, dest, flag_we}.
REQ-020 The block SHALL hold a 2-entry in-order buffer with states EMPTY, ONE, FULL; pending SHALL be 0, 1, 2 respectively.
REQ-021 in_ready SHALL be combinational: high in EMPTY and ONE, low in FULL, independent of commit_en (no same-cycle pass-through when FULL).
REQ-022 A retire SHALL occur on a rising edge when commit_en is high and state is not EMPTY; the oldest entry is retired.
REQ-023 On retire, register[dest] SHALL take the entry result; if flag_we, flags SHALL take {ovf, equ, carry}, else flags unchanged.
REQ-024 Transitions: EMPTY + accept -> ONE; ONE + accept only -> FULL; ONE + retire only -> EMPTY; ONE + accept and retire -> ONE, new entry becomes oldest; FULL + retire -> ONE; otherwise hold.
REQ-025 EMPTY with accept and commit_en SHALL NOT retire the incoming entry the same cycle; retire happens on the next edge at the earliest (1-cycle minimum latency from accept to visible register/flag update).
REQ-026 in_valid while in_ready is low SHALL be ignored; no state change, no data loss of buffered entries.
REQ-027 rd_a/rd_b/carry_fb SHALL reflect only committed state; no bypass from buffered entries; the issuing stage owns hazard handling using pending.
REQ-028 commit_count SHALL increment by 1 per retire and wrap from 16'hFFFF to 16'h0000.
REQ-029 rd_a_idx == rd_b_idx SHALL return the same value on both ports.

Reset
REQ-030 While rst is high, registers R0..R3 = 12'h000, flags = 3'b000, carry_fb = 0, state EMPTY, pending = 0, commit_count = 0, in_ready = 1.
REQ-031 Reset asserted mid-operation SHALL discard buffered entries immediately without retiring them.
REQ-032 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-033 After reset: in_valid=1, result 12'h123, dest 2, flag_we=1, carry=1, equ=0, ovf=0, commit_en=1 -> next cycle pending=1; following edge R2=12'h123, flags=3'b001, carry_fb=1, commit_count=1.
REQ-034 commit_en=0, three back-to-back results 12'hAAA, 12'h555, 12'hFFF to R0 -> pending 1, 2, in_ready=0, third ignored; then commit_en=1 -> R0=12'hAAA, then 12'h555, pending returns to 0.
REQ-035 State ONE, accept 12'h7FF to R1 and retire together -> pending stays 1; next retire writes R1=12'h7FF.
REQ-036 flag_we=0 with carry=1, ovf=1, result 12'h800 to R3 -> R3=12'h800, flags unchanged from prior value.
REQ-037 FULL buffer, assert rst for one cycle -> pending=0, all registers 0, flags 0, commit_count 0, no retire occurs.
REQ-038 65536 retires -> commit_count wraps to 16'h0000.

Source files
------------

// File: rtl/alu_wb.sv
// ALU writeback stage: two-entry in-order result buffer that retires into a
// four-entry register file and a {V, E, C} flags register.

package alu_wb_pkg;
  localparam int unsigned RES_W    = 12;
  localparam int unsigned DEST_W   = 2;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned FLAG_W   = 3;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned PEND_W   = 2;

  // One buffered ALU result awaiting retirement
  typedef struct packed {
    logic [RES_W-1:0]  result;
    logic              carry;
    logic              equ;
    logic              ovf;
    logic [DEST_W-1:0] dest;
    logic              flag_we;
  } wb_entry_t;
endpackage

module alu_wb
  import alu_wb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RES_W-1:0]    in_result,
  input  logic                in_carry,
  input  logic                in_equ,
  input  logic                in_ovf,
  input  logic [DEST_W-1:0]   in_dest,
  input  logic                in_flag_we,
  input  logic                commit_en,
  input  logic [DEST_W-1:0]   rd_a_idx,
  input  logic [DEST_W-1:0]   rd_b_idx,
  output logic [RES_W-1:0]    rd_a,
  output logic [RES_W-1:0]    rd_b,
  output logic                carry_fb,
  output logic [FLAG_W-1:0]   flags,
  output logic [PEND_W-1:0]   pending,
  output logic [CNT_W-1:0]    commit_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  wb_entry_t         slot0_q, slot0_d;   // oldest entry
  wb_entry_t         slot1_q, slot1_d;   // younger entry, valid only in FULL
  logic [RES_W-1:0]  regs_q [NUM_REGS];
  logic [RES_W-1:0]  regs_d [NUM_REGS];
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [CNT_W-1:0]  count_q, count_d;

  wb_entry_t         new_entry;
  logic              accept;
  logic              retire;

  // Next-state, buffer movement and retirement into architectural state
  always_comb begin
    state_d  = state_q;
    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    regs_d   = regs_q;
    flags_d  = flags_q;
    count_d  = count_q;
    in_ready = 1'b0;
    pending  = PEND_W'(0);

    new_entry = '{result:  in_result,
                  carry:   in_carry,
                  equ:     in_equ,
                  ovf:     in_ovf,
                  dest:    in_dest,
                  flag_we: in_flag_we};

    in_ready = (state_q != FULL);
    accept   = in_valid && in_ready;
    retire   = commit_en && (state_q != EMPTY);

    if (retire) begin
      regs_d[slot0_q.dest] = slot0_q.result;
      if (slot0_q.flag_we) begin
        flags_d = {slot0_q.ovf, slot0_q.equ, slot0_q.carry};
      end
      count_d = count_q + CNT_W'(1);
    end

    case (state_q)
      EMPTY: begin
        pending = PEND_W'(0);
        if (accept) begin
          slot0_d = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        pending = PEND_W'(1);
        if (accept && retire) begin
          slot0_d = new_entry;
        end else if (accept) begin
          slot1_d = new_entry;
          state_d = FULL;
        end else if (retire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        pending = PEND_W'(2);
        if (retire) begin
          slot0_d = slot1_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State, buffer and architectural registers; reset discards buffered entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
      flags_q <= '0;
      count_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      flags_q <= flags_d;
      count_q <= count_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Committed-state read ports; no bypass from buffered entries
  always_comb begin
    rd_a         = regs_q[rd_a_idx];
    rd_b         = regs_q[rd_b_idx];
    flags        = flags_q;
    carry_fb     = flags_q[0];
    commit_count = count_q;
  end

endmodule

// File: tb/tb_alu_wb.sv
// Directed testbench for alu_wb with hand-computed expectations.

module tb_alu_wb;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_result;
  logic        in_carry;
  logic        in_equ;
  logic        in_ovf;
  logic [1:0]  in_dest;
  logic        in_flag_we;
  logic        commit_en;
  logic [1:0]  rd_a_idx;
  logic [1:0]  rd_b_idx;
  logic [11:0] rd_a;
  logic [11:0] rd_b;
  logic        carry_fb;
  logic [2:0]  flags;
  logic [1:0]  pending;
  logic [15:0] commit_count;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_wb dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_carry     (in_carry),
    .in_equ       (in_equ),
    .in_ovf       (in_ovf),
    .in_dest      (in_dest),
    .in_flag_we   (in_flag_we),
    .commit_en    (commit_en),
    .rd_a_idx     (rd_a_idx),
    .rd_b_idx     (rd_b_idx),
    .rd_a         (rd_a),
    .rd_b         (rd_b),
    .carry_fb     (carry_fb),
    .flags        (flags),
    .pending      (pending),
    .commit_count (commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Read one register through both ports and check both
  task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [11:0] exp);
    rd_a_idx = idx;
    rd_b_idx = idx;
    #1;
    chk({tag, ".a"}, 16'(rd_a), 16'(exp));
    chk({tag, ".b"}, 16'(rd_b), 16'(exp));
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [11:0] r, input logic [1:0] d,
                       input logic fwe, input logic c, input logic e, input logic o);
    in_valid   = v;
    in_result  = r;
    in_dest    = d;
    in_flag_we = fwe;
    in_carry   = c;
    in_equ     = e;
    in_ovf     = o;
  endtask

  initial begin
    rst       = 1'b1;
    commit_en = 1'b0;
    rd_a_idx  = 2'd0;
    rd_b_idx  = 2'd0;
    drive(1'b0, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    tick();
    tick();
    chk("rst.pending", 16'(pending), 16'h0);
    chk("rst.in_ready", 16'(in_ready), 16'h1);
    chk("rst.flags", 16'(flags), 16'h0);
    chk("rst.carry_fb", 16'(carry_fb), 16'h0);
    chk("rst.count", commit_count, 16'h0);
    tick();
    chk_reg("rst.r0", 2'd0, 12'h000);
    chk_reg("rst.r1", 2'd1, 12'h000);
    chk_reg("rst.r2", 2'd2, 12'h000);
    chk_reg("rst.r3", 2'd3, 12'h000);

    // First accept right after reset release; retire one edge later
    tick();
    rst       = 1'b0;
    drive(1'b1, 12'h123, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    commit_en = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("first.pending", 16'(pending), 16'h1);
    chk("first.flags_early", 16'(flags), 16'h0);
    chk_reg("first.r2_early", 2'd2, 12'h000);
    tick();
    chk("first.pending2", 16'(pending), 16'h0);
    chk("first.flags", 16'(flags), 16'h1);
    chk("first.carry_fb", 16'(carry_fb), 16'h1);
    chk("first.count", commit_count, 16'h1);
    chk_reg("first.r2", 2'd2, 12'h123);

    // Fill buffer, third result ignored, then drain in order
    commit_en = 1'b0;
    drive(1'b1, 12'hAAA, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fill.pending1", 16'(pending), 16'h1);
    chk("fill.ready1", 16'(in_ready), 16'h1);
    in_result = 12'h555;
    tick();
    chk("fill.pending2", 16'(pending), 16'h2);
    chk("fill.ready2", 16'(in_ready), 16'h0);
    in_result = 12'hFFF;
    tick();
    chk("fill.ignored", 16'(pending), 16'h2);
    in_valid  = 1'b0;
    commit_en = 1'b1;
    tick();
    chk("drain.pending1", 16'(pending), 16'h1);
    chk("drain.count1", commit_count, 16'h2);
    chk_reg("drain.r0_a", 2'd0, 12'hAAA);
    tick();
    chk("drain.pending0", 16'(pending), 16'h0);
    chk("drain.count2", commit_count, 16'h3);
    chk("drain.flags", 16'(flags), 16'h1);
    chk_reg("drain.r0_b", 2'd0, 12'h555);
    tick();
    chk("drain.no_fff", commit_count, 16'h3);
    chk_reg("drain.r0_c", 2'd0, 12'h555);

    // Accept and retire together while holding one entry
    commit_en = 1'b0;
    drive(1'b1, 12'h111, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("ovl.pending_a", 16'(pending), 16'h1);
    in_result = 12'h7FF;
    commit_en = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ovl.pending_b", 16'(pending), 16'h1);
    chk("ovl.count_a", commit_count, 16'h4);
    chk_reg("ovl.r1_a", 2'd1, 12'h111);
    tick();
    chk("ovl.pending_c", 16'(pending), 16'h0);
    chk("ovl.count_b", commit_count, 16'h5);
    chk_reg("ovl.r1_b", 2'd1, 12'h7FF);

    // Set flags to E only, then a flag_we=0 result must leave them alone
    drive(1'b1, 12'h042, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("fl.flags_e", 16'(flags), 16'h2);
    chk("fl.carry_fb0", 16'(carry_fb), 16'h0);
    chk_reg("fl.r3_a", 2'd3, 12'h042);
    drive(1'b1, 12'h800, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("fl.flags_kept", 16'(flags), 16'h2);
    chk("fl.carry_kept", 16'(carry_fb), 16'h0);
    chk("fl.count", commit_count, 16'h7);
    chk_reg("fl.r3_b", 2'd3, 12'h800);

    // Reset with a full buffer discards both entries
    commit_en = 1'b0;
    drive(1'b1, 12'h321, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    in_result = 12'h654;
    in_dest   = 2'd1;
    tick();
    in_valid = 1'b0;
    chk("mrst.full", 16'(pending), 16'h2);
    rst       = 1'b1;
    commit_en = 1'b1;
    #1;
    chk("mrst.pending", 16'(pending), 16'h0);
    chk("mrst.flags", 16'(flags), 16'h0);
    chk("mrst.count", commit_count, 16'h0);
    chk("mrst.ready", 16'(in_ready), 16'h1);
    chk_reg("mrst.r0", 2'd0, 12'h000);
    chk_reg("mrst.r1", 2'd1, 12'h000);
    chk_reg("mrst.r3", 2'd3, 12'h000);
    tick();
    rst = 1'b0;
    tick();
    chk("mrst.no_retire", commit_count, 16'h0);
    chk("mrst.pending2", 16'(pending), 16'h0);
    chk_reg("mrst.r0_after", 2'd0, 12'h000);
    chk_reg("mrst.r1_after", 2'd1, 12'h000);

    // Streaming retires until the counter wraps
    drive(1'b1, 12'h0F0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    commit_en = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      tick();
    end
    chk("wrap.ffff", commit_count, 16'hFFFF);
    chk("wrap.pending", 16'(pending), 16'h1);
    in_valid = 1'b0;
    tick();
    chk("wrap.zero", commit_count, 16'h0000);
    chk("wrap.empty", 16'(pending), 16'h0);
    chk_reg("wrap.r0", 2'd0, 12'h0F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
